// File: rtl/river_pkg.sv
// Shared encodings for the river-crossing puzzle controller and its display logic.
package river_pkg;

  typedef enum logic [1:0] {
    PLAY = 2'b00,
    WIN  = 2'b01,
    LOSE = 2'b10
  } state_e;

  localparam logic [1:0] SEL_ALONE = 2'b00;
  localparam logic [1:0] SEL_CAB   = 2'b01;
  localparam logic [1:0] SEL_GOAT  = 2'b10;
  localparam logic [1:0] SEL_WOLF  = 2'b11;

endpackage

// File: rtl/river_danger.sv
// Flags a position where the goat or cabbage is left unattended with its predator.
module river_danger (
  input  logic f,
  input  logic c,
  input  logic g,
  input  logic w,
  output logic unsafe
);

  assign unsafe = ((g == w) && (f != g)) || ((c == g) && (f != c));

endmodule

// File: rtl/river_crossing_ctrl.sv
// Game controller: one move per button press, legality and danger checks,
// move counting and WIN/LOSE tracking.
module river_crossing_ctrl
  import river_pkg::*;
#(
  parameter int unsigned MOVE_W     = 8,
  parameter int unsigned MOVE_LIMIT = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              move,
  input  logic [1:0]        sel,
  output logic              f,
  output logic              c,
  output logic              g,
  output logic              w,
  output logic              alarm,
  output logic              win,
  output logic              lose,
  output logic              illegal,
  output logic [MOVE_W-1:0] moves,
  output logic [1:0]        state
);

  localparam logic [MOVE_W-1:0] LimitVal = MOVE_W'(MOVE_LIMIT);

  state_e            state_q;
  logic              move_prev;
  logic              req;
  logic              pass_bank;
  logic              legal;
  logic              nf, nc, ng, nw;
  logic              n_unsafe;
  logic [MOVE_W-1:0] n_moves;

  assign req   = move & ~move_prev;
  assign state = state_q;

  always_comb begin
    pass_bank = f;
    unique case (sel)
      SEL_CAB:  pass_bank = c;
      SEL_GOAT: pass_bank = g;
      SEL_WOLF: pass_bank = w;
      default:  pass_bank = f;
    endcase
  end

  assign legal = (sel == SEL_ALONE) || (pass_bank == f);

  // Candidate position if the current request is accepted.
  assign nf = ~f;
  assign nc = (sel == SEL_CAB)  ? ~c : c;
  assign ng = (sel == SEL_GOAT) ? ~g : g;
  assign nw = (sel == SEL_WOLF) ? ~w : w;

  assign n_moves = (moves == '1) ? moves : moves + MOVE_W'(1);

  river_danger u_danger (
    .f      (nf),
    .c      (nc),
    .g      (ng),
    .w      (nw),
    .unsafe (n_unsafe)
  );

  always_ff @(posedge clk) begin
    // Tracking move through reset keeps a held button from firing on release of reset.
    move_prev <= move;
    if (reset) begin
      f       <= 1'b0;
      c       <= 1'b0;
      g       <= 1'b0;
      w       <= 1'b0;
      moves   <= '0;
      state_q <= PLAY;
      alarm   <= 1'b0;
      win     <= 1'b0;
      lose    <= 1'b0;
      illegal <= 1'b0;
    end else begin
      illegal <= 1'b0;
      if (state_q == PLAY && req) begin
        if (!legal) begin
          illegal <= 1'b1;
        end else begin
          f     <= nf;
          c     <= nc;
          g     <= ng;
          w     <= nw;
          moves <= n_moves;
          if (nf && nc && ng && nw) begin
            state_q <= WIN;
            win     <= 1'b1;
          end else if (n_unsafe) begin
            state_q <= LOSE;
            lose    <= 1'b1;
            alarm   <= 1'b1;
          end else if (MOVE_LIMIT != 0 && n_moves == LimitVal) begin
            state_q <= LOSE;
            lose    <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_river_crossing_ctrl.sv
// Directed bench for river_crossing_ctrl: unlimited instance plus a MOVE_LIMIT=3 instance.
module tb_river_crossing_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       move = 1'b0;
  logic [1:0] sel = 2'b00;

  logic       f, c, g, w, alarm, win, lose, illegal;
  logic [7:0] moves;
  logic [1:0] state;
  logic       f2, c2, g2, w2, alarm2, win2, lose2, illegal2;
  logic [7:0] moves2;
  logic [1:0] state2;

  int unsigned nvec = 0;
  int unsigned nerr = 0;

  always #5 clk = ~clk;

  river_crossing_ctrl #(.MOVE_W(8), .MOVE_LIMIT(0)) dut (
    .clk(clk), .reset(reset), .move(move), .sel(sel),
    .f(f), .c(c), .g(g), .w(w), .alarm(alarm), .win(win), .lose(lose),
    .illegal(illegal), .moves(moves), .state(state)
  );

  river_crossing_ctrl #(.MOVE_W(8), .MOVE_LIMIT(3)) dut_lim (
    .clk(clk), .reset(reset), .move(move), .sel(sel),
    .f(f2), .c(c2), .g(g2), .w(w2), .alarm(alarm2), .win(win2), .lose(lose2),
    .illegal(illegal2), .moves(moves2), .state(state2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Press and release; returns on the falling edge after the acting rising edge.
  task automatic press(input logic [1:0] s);
    @(negedge clk);
    sel  = s;
    move = 1'b1;
    @(negedge clk);
    move = 1'b0;
  endtask

  logic [1:0] opt_sel [7] = '{2'b10, 2'b00, 2'b11, 2'b10, 2'b01, 2'b00, 2'b10};
  logic [3:0] opt_pos [7] = '{4'b1010, 4'b0010, 4'b1011, 4'b0001, 4'b1101, 4'b0101, 4'b1111};

  initial begin
    do_reset();
    @(negedge clk);
    check("rst_pos", {f, c, g, w}, 4'b0000);
    check("rst_moves", moves, 0);
    check("rst_state", state, 2'b00);
    check("rst_flags", {alarm, win, lose, illegal}, 4'b0000);

    // Optimal solution
    for (int i = 0; i < 7; i++) begin
      press(opt_sel[i]);
      check($sformatf("opt_pos%0d", i), {f, c, g, w}, opt_pos[i]);
    end
    check("opt_win", win, 1);
    check("opt_lose", lose, 0);
    check("opt_moves", moves, 7);
    check("opt_state", state, 2'b01);
    press(2'b00);
    check("win_ignore_pos", {f, c, g, w}, 4'b1111);
    check("win_ignore_moves", moves, 7);
    check("win_no_illegal", illegal, 0);

    // Farmer leaves alone: goat with wolf and cabbage
    do_reset();
    press(2'b00);
    check("alone_pos", {f, c, g, w}, 4'b1000);
    check("alone_lose", lose, 1);
    check("alone_alarm", alarm, 1);
    check("alone_moves", moves, 1);
    check("alone_state", state, 2'b10);
    press(2'b10);
    check("lose_ignore_pos", {f, c, g, w}, 4'b1000);
    check("lose_ignore_moves", moves, 1);
    check("lose_no_illegal", illegal, 0);

    // Passenger on wrong bank
    do_reset();
    press(2'b10);
    check("ill_pre_pos", {f, c, g, w}, 4'b1010);
    press(2'b01);
    check("ill_pulse", illegal, 1);
    check("ill_pos", {f, c, g, w}, 4'b1010);
    check("ill_moves", moves, 1);
    check("ill_state", state, 2'b00);
    @(negedge clk);
    check("ill_pulse_end", illegal, 0);

    // Held button gives one request
    do_reset();
    @(negedge clk);
    sel  = 2'b10;
    move = 1'b1;
    repeat (6) @(negedge clk);
    check("hold_moves", moves, 1);
    check("hold_pos", {f, c, g, w}, 4'b1010);
    move = 1'b0;
    @(negedge clk);
    press(2'b10);
    check("hold_again_pos", {f, c, g, w}, 4'b0000);
    check("hold_again_moves", moves, 2);

    // Move limit of 3 on the second instance
    do_reset();
    press(2'b10);
    press(2'b10);
    press(2'b10);
    check("lim_moves", moves2, 3);
    check("lim_lose", lose2, 1);
    check("lim_alarm", alarm2, 0);
    check("lim_state", state2, 2'b10);
    check("nolim_lose", lose, 0);
    check("nolim_moves", moves, 3);

    // Mid-game reset with move held across it
    @(negedge clk);
    reset = 1'b1;
    move  = 1'b1;
    sel   = 2'b10;
    @(negedge clk);
    check("mid_rst_pos", {f, c, g, w}, 4'b0000);
    check("mid_rst_moves", moves, 0);
    check("mid_rst_flags", {alarm, win, lose, illegal}, 4'b0000);
    check("mid_rst_lim", {lose2, moves2}, 9'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("held_after_rst_moves", moves, 0);
    check("held_after_rst_pos", {f, c, g, w}, 4'b0000);
    move = 1'b0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
